// File: rtl/adder_sum_accum.sv
// rtl/adder_sum_accum.sv - block accumulator for pipelined adder results (optional ACCUM_SAT_EN saturation)
module adder_sum_accum #(
    parameter int DATA_W    = 8,
    parameter int BLOCK_LEN = 16,
    parameter int ACC_W     = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              clr,
    input  logic              din_valid,
    input  logic [DATA_W-1:0] din_sum,
    input  logic              din_cout,
    output logic [ACC_W-1:0]  dout,
    output logic              dout_valid,
    input  logic              dout_ready,
    output logic              dout_ovf,
    output logic              overrun,
    output logic [7:0]        blk_cnt
);

    localparam int CNT_W = (BLOCK_LEN > 2) ? $clog2(BLOCK_LEN) : 1;
    localparam logic [CNT_W-1:0] LAST = CNT_W'(BLOCK_LEN - 1);

    typedef enum logic {IDLE, ACCUM} state_t;

    state_t            state, state_nxt;
    logic [ACC_W-1:0]  acc, acc_nxt;
    logic [CNT_W-1:0]  cnt, cnt_nxt;
    logic              ovf, ovf_nxt;
    logic [ACC_W:0]    sample_ext;
    logic [ACC_W:0]    sum_ext;
    logic              carry;
    logic [ACC_W-1:0]  add_res;
    logic              complete;

    assign sample_ext = {{(ACC_W - DATA_W){1'b0}}, din_cout, din_sum};
    assign sum_ext    = {1'b0, acc} + sample_ext;
    assign carry      = sum_ext[ACC_W];

`ifdef ACCUM_SAT_EN
    // Once clamped, every later add carries again (or adds 0), so acc stays at max.
    assign add_res = carry ? {ACC_W{1'b1}} : sum_ext[ACC_W-1:0];
`else
    assign add_res = sum_ext[ACC_W-1:0];
`endif

    assign complete = din_valid && !clr && (state == ACCUM) && (cnt == LAST);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= IDLE;
            acc   <= '0;
            cnt   <= '0;
            ovf   <= 1'b0;
        end else begin
            state <= state_nxt;
            acc   <= acc_nxt;
            cnt   <= cnt_nxt;
            ovf   <= ovf_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        acc_nxt   = acc;
        cnt_nxt   = cnt;
        ovf_nxt   = ovf;
        if (clr || complete) begin
            state_nxt = IDLE;
            acc_nxt   = '0;
            cnt_nxt   = '0;
            ovf_nxt   = 1'b0;
        end else if (din_valid) begin
            state_nxt = ACCUM;
            acc_nxt   = add_res;
            cnt_nxt   = cnt + 1'b1;
            ovf_nxt   = ovf | carry;
        end
    end

    // A completing block always wins the output register, even over an accept.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            dout       <= '0;
            dout_valid <= 1'b0;
            dout_ovf   <= 1'b0;
            overrun    <= 1'b0;
            blk_cnt    <= '0;
        end else if (complete) begin
            dout       <= add_res;
            dout_ovf   <= ovf | carry;
            dout_valid <= 1'b1;
            blk_cnt    <= blk_cnt + 8'd1;
            if (dout_valid && !dout_ready)
                overrun <= 1'b1;
        end else if (dout_valid && dout_ready) begin
            dout_valid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_adder_sum_accum.sv
// tb/tb_adder_sum_accum.sv - scoreboard bench for adder_sum_accum (ACC_W=12)
module tb_adder_sum_accum;

    localparam int AW   = 12;
    localparam int BLK  = 16;
    localparam int MAXV = 4095;

    logic          clk = 1'b0;
    logic          rst_n, clr, din_valid, din_cout, dout_ready;
    logic [7:0]    din_sum;
    logic [AW-1:0] dout;
    logic          dout_valid, dout_ovf, overrun;
    logic [7:0]    blk_cnt;

    int n_vec = 0;
    int n_err = 0;

    int   macc, mcnt, mblk;
    logic movf, mv, movr;
    logic [AW:0] sbq[$];

    adder_sum_accum #(.DATA_W(8), .BLOCK_LEN(BLK), .ACC_W(AW)) dut (
        .clk(clk), .rst_n(rst_n), .clr(clr), .din_valid(din_valid),
        .din_sum(din_sum), .din_cout(din_cout), .dout(dout),
        .dout_valid(dout_valid), .dout_ready(dout_ready), .dout_ovf(dout_ovf),
        .overrun(overrun), .blk_cnt(blk_cnt)
    );

    always #5 clk = ~clk;

    task automatic step(input logic v, input logic c, input logic [8:0] s, input logic rdy);
        logic [AW:0] e;
        int   t, nv;
        logic cy, mo, done;
        din_valid  = v;
        clr        = c;
        din_sum    = s[7:0];
        din_cout   = s[8];
        dout_ready = rdy;
        #1;
        n_vec++;
        if (dout_valid !== mv) begin
            n_err++;
            $display("FAIL dout_valid: got %b want %b", dout_valid, mv);
        end
        n_vec++;
        if (overrun !== movr) begin
            n_err++;
            $display("FAIL overrun: got %b want %b", overrun, movr);
        end
        n_vec++;
        if (blk_cnt !== 8'(mblk)) begin
            n_err++;
            $display("FAIL blk_cnt: got %0d want %0d", blk_cnt, mblk);
        end
        if (mv && rdy) begin
            n_vec++;
            if (sbq.size() == 0) begin
                n_err++;
                $display("FAIL accept: got block %0d with empty scoreboard want none", dout);
            end else begin
                e = sbq.pop_front();
                if ({dout_ovf, dout} !== e) begin
                    n_err++;
                    $display("FAIL block: got sum %0d ovf %b want sum %0d ovf %b",
                             dout, dout_ovf, e[AW-1:0], e[AW]);
                end
            end
        end
        done = 1'b0;
        if (c) begin
            macc = 0; mcnt = 0; movf = 1'b0;
        end else if (v) begin
            t  = macc + int'(s);
            cy = (t > MAXV);
`ifdef ACCUM_SAT_EN
            nv = cy ? MAXV : t;
`else
            nv = t % (MAXV + 1);
`endif
            mo = movf | cy;
            if (mcnt == BLK - 1) begin
                done = 1'b1;
                if (mv && !rdy) begin
                    if (sbq.size() != 0) void'(sbq.pop_front());
                    movr = 1'b1;
                end
                sbq.push_back({mo, AW'(nv)});
                mblk = (mblk + 1) % 256;
                macc = 0; mcnt = 0; movf = 1'b0;
            end else begin
                macc = nv; mcnt++; movf = mo;
            end
        end
        if (done) mv = 1'b1;
        else if (mv && rdy) mv = 1'b0;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; din_valid = 1'b0; clr = 1'b0; dout_ready = 1'b0;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        macc = 0; mcnt = 0; movf = 1'b0; mv = 1'b0; movr = 1'b0; mblk = 0;
        sbq.delete();
        n_vec++;
        if ({dout, dout_valid, dout_ovf, overrun, blk_cnt} !== '0) begin
            n_err++;
            $display("FAIL reset: got dout %0d v %b ovf %b ovr %b blk %0d want all 0",
                     dout, dout_valid, dout_ovf, overrun, blk_cnt);
        end
    endtask

    task automatic test_stream();
        test_reset();
        for (int k = 0; k < 2 * BLK; k++) step(1'b1, 1'b0, 9'(k + 10 + k), 1'b1);
        for (int k = 0; k < 3; k++) step(1'b0, 1'b0, 9'd0, 1'b1);
        n_vec++;
        if (dout !== AW'(912) || dout_ovf !== 1'b0 || blk_cnt !== 8'd2 || overrun !== 1'b0) begin
            n_err++;
            $display("FAIL stream: got %0d/%b/%0d/%b want 912/0/2/0", dout, dout_ovf, blk_cnt, overrun);
        end
    endtask

    task automatic test_overrun();
        test_reset();
        for (int k = 0; k < 2 * BLK; k++) step(1'b1, 1'b0, 9'(2 * k + 10), 1'b0);
        for (int k = 0; k < 8; k++) step(1'b0, 1'b0, 9'd0, 1'b0);
        n_vec++;
        if (dout !== AW'(912) || overrun !== 1'b1 || blk_cnt !== 8'd2 || dout_valid !== 1'b1) begin
            n_err++;
            $display("FAIL overrun_hold: got %0d/%b/%0d/%b want 912/1/2/1", dout, overrun, blk_cnt, dout_valid);
        end
        step(1'b0, 1'b0, 9'd0, 1'b1);
        step(1'b0, 1'b0, 9'd0, 1'b1);
        n_vec++;
        if (dout_valid !== 1'b0 || sbq.size() != 0) begin
            n_err++;
            $display("FAIL overrun_drain: got valid %b pending %0d want 0 0", dout_valid, sbq.size());
        end
    endtask

    task automatic test_back_to_back();
        test_reset();
        for (int k = 0; k < 2 * BLK; k++) step(1'b1, 1'b0, 9'(2 * k + 10), k == 2 * BLK - 1);
        step(1'b0, 1'b0, 9'd0, 1'b0);
        n_vec++;
        if (dout !== AW'(912) || dout_valid !== 1'b1 || overrun !== 1'b0) begin
            n_err++;
            $display("FAIL accept_on_complete: got %0d/%b/%b want 912/1/0", dout, dout_valid, overrun);
        end
        step(1'b0, 1'b0, 9'd0, 1'b1);
    endtask

    task automatic test_overflow();
        test_reset();
        for (int k = 0; k < BLK; k++) step(1'b1, 1'b0, 9'd511, 1'b0);
        n_vec++;
`ifdef ACCUM_SAT_EN
        if (dout !== AW'(4095) || dout_ovf !== 1'b1) begin
            n_err++;
            $display("FAIL overflow: got %0d/%b want 4095/1", dout, dout_ovf);
        end
`else
        if (dout !== AW'(4080) || dout_ovf !== 1'b1) begin
            n_err++;
            $display("FAIL overflow: got %0d/%b want 4080/1", dout, dout_ovf);
        end
`endif
        step(1'b0, 1'b0, 9'd0, 1'b1);
    endtask

    task automatic test_clear();
        test_reset();
        for (int k = 1; k <= 5; k++) step(1'b1, 1'b0, 9'(k), 1'b1);
        step(1'b1, 1'b1, 9'd99, 1'b1);
        for (int k = 0; k < BLK; k++) step(1'b1, 1'b0, 9'(3 * k + 1), 1'b0);
        n_vec++;
        if (dout !== AW'(376) || dout_valid !== 1'b1 || blk_cnt !== 8'd1) begin
            n_err++;
            $display("FAIL clear: got %0d/%b/%0d want 376/1/1", dout, dout_valid, blk_cnt);
        end
        step(1'b0, 1'b0, 9'd0, 1'b1);
    endtask

    task automatic test_mid_reset();
        test_reset();
        for (int k = 0; k < BLK + 3; k++) step(1'b1, 1'b0, 9'(k + 7), 1'b0);
        test_reset();
        for (int k = 0; k < BLK; k++) step(1'b1, 1'b0, 9'd2, 1'b0);
        n_vec++;
        if (dout !== AW'(32) || blk_cnt !== 8'd1) begin
            n_err++;
            $display("FAIL mid_reset: got %0d/%0d want 32/1", dout, blk_cnt);
        end
        step(1'b0, 1'b0, 9'd0, 1'b1);
    endtask

    initial begin
        rst_n = 1'b0; clr = 1'b0; din_valid = 1'b0; din_sum = '0; din_cout = 1'b0; dout_ready = 1'b0;
        @(posedge clk);
        #1;
        test_reset();
        test_stream();
        test_overrun();
        test_back_to_back();
        test_overflow();
        test_clear();
        test_mid_reset();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
